// File: rtl/vedic_2x2_pkg.sv
// vedic_2x2_pkg: shared widths for the 2x2 Vedic multiplier cell
package vedic_2x2_pkg;
    localparam int OP_W   = 2;
    localparam int PROD_W = 4;
endpackage

// File: rtl/vedic_2x2_if.sv
// vedic_2x2_if: operand/product bus; master drives in_valid/a/b, slave returns out_valid/p
interface vedic_2x2_if;
    import vedic_2x2_pkg::*;
    logic              in_valid;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic [PROD_W-1:0] p;
    modport master (output in_valid, a, b, input out_valid, p);
    modport slave  (input in_valid, a, b, output out_valid, p);
endinterface

// File: rtl/vedic_2x2_half_adder.sv
// vedic_half_adder: 1-bit half adder; x,y in, s = x^y, c = x&y out
module vedic_half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: rtl/vedic_2x2.sv
// vedic_2x2: registered 2x2 unsigned Urdhva-Tiryagbhyam multiplier; clk, rst_n (sync, active-low), bus (slave: in_valid/a/b in, out_valid/p out)
module vedic_2x2
    import vedic_2x2_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    vedic_2x2_if.slave  bus
);
    logic              pp00, pp10, pp01, pp11, c1;
    logic [PROD_W-1:0] prod;
    assign pp00    = bus.a[0] & bus.b[0];
    assign pp10    = bus.a[1] & bus.b[0];
    assign pp01    = bus.a[0] & bus.b[1];
    assign pp11    = bus.a[1] & bus.b[1];
    assign prod[0] = pp00;
    vedic_half_adder ha1 (.x(pp10), .y(pp01), .s(prod[1]), .c(c1));
    vedic_half_adder ha2 (.x(pp11), .y(c1),   .s(prod[2]), .c(prod[3]));
    // p only loads on in_valid, so operand junk while idle never reaches it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.p         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) bus.p <= prod;
        end
    end
endmodule

// File: tb/tb_vedic_2x2.sv
// tb_vedic_2x2: randomized and directed self-checking bench for vedic_2x2
module tb_vedic_2x2;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    vedic_2x2_if bus();
    vedic_2x2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic v, input logic [1:0] x, input logic [1:0] y);
        rst_n        = r;
        bus.in_valid = v;
        bus.a        = x;
        bus.b        = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 2'd3, 2'd3);
            step();
            tests++;
            if (bus.p !== 4'd0 || bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: p=%0d ov=%b, want p=0 ov=0", i, bus.p, bus.out_valid);
            end
        end
        drive(1'b1, 1'b1, 2'd3, 2'd3);
        step();
        tests++;
        if (bus.p !== 4'd9 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: p=%0d ov=%b, want p=9 ov=1", bus.p, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        int ta [5] = '{0, 1, 2, 3, 3};
        int tb [5] = '{0, 1, 2, 1, 2};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 2'(ta[i]), 2'(tb[i]));
            step();
            tests++;
            if (bus.p !== 4'(ta[i] * tb[i]) || bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL basic %0dx%0d: p=%0d ov=%b, want p=%0d ov=1", ta[i], tb[i], bus.p, bus.out_valid, ta[i] * tb[i]);
            end
        end
    endtask

    task automatic test_carry();
        drive(1'b1, 1'b1, 2'd3, 2'd3);
        step();
        tests++;
        if (bus.p !== 4'b1001 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL carry 3x3: p=%b ov=%b, want p=1001 ov=1", bus.p, bus.out_valid);
        end
    endtask

    task automatic test_exhaustive();
        int pulses = 0;
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) begin
                drive(1'b1, 1'b1, 2'(x), 2'(y));
                step();
                if (bus.out_valid === 1'b1) pulses++;
                tests++;
                if (bus.p !== 4'(x * y)) begin
                    fails++;
                    $display("FAIL exhaustive %0dx%0d: p=%0d, want %0d", x, y, bus.p, x * y);
                end
            end
        tests++;
        if (pulses != 16) begin
            fails++;
            $display("FAIL exhaustive_pulses: got %0d, want 16", pulses);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b1, 2'd3, 2'd2);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'($urandom), 2'($urandom));
            if (i == 0) bus.a = 2'd3;
            step();
            tests++;
            if (bus.p !== 4'b0110 || bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: p=%b ov=%b, want p=0110 ov=0", i, bus.p, bus.out_valid);
            end
        end
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 1'b1, 2'd1, 2'd1);
        step();
        drive(1'b0, 1'b1, 2'd2, 2'd3);
        step();
        tests++;
        if (bus.p !== 4'd0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: p=%0d ov=%b, want p=0 ov=0", bus.p, bus.out_valid);
        end
        drive(1'b1, 1'b0, 2'd2, 2'd3);
        step();
        tests++;
        if (bus.p !== 4'd0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_late: p=%0d ov=%b, want p=0 ov=0", bus.p, bus.out_valid);
        end
        drive(1'b1, 1'b1, 2'd2, 2'd3);
        step();
        tests++;
        if (bus.p !== 4'd6 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_resume: p=%0d ov=%b, want p=6 ov=1", bus.p, bus.out_valid);
        end
    endtask

    task automatic test_random();
        int exp_p  = 0;
        int exp_ov = 0;
        // sync with a known state first
        drive(1'b0, 1'b0, 2'd0, 2'd0);
        step();
        for (int i = 0; i < 200; i++) begin
            logic r, v;
            logic [1:0] x, y;
            r = ($urandom_range(0, 19) != 0);
            v = 1'($urandom);
            x = 2'($urandom);
            y = 2'($urandom);
            drive(r, v, x, y);
            step();
            if (!r) begin
                exp_p  = 0;
                exp_ov = 0;
            end else begin
                exp_ov = int'(v);
                if (v) exp_p = int'(x) * int'(y);
            end
            tests++;
            if (bus.p !== 4'(exp_p) || bus.out_valid !== 1'(exp_ov)) begin
                fails++;
                $display("FAIL random[%0d]: p=%0d ov=%b, want p=%0d ov=%0d", i, bus.p, bus.out_valid, exp_p, exp_ov);
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'd0, 2'd0);
        test_reset();
        test_basic();
        test_carry();
        test_exhaustive();
        test_hold();
        test_midstream_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
